// File: rtl/echo_effect_pkg.sv
// Shared types for the echo stage: FSM state encoding and the dry-bypass timing
// used while the delay buffer is being cleared.
package echo_effect_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_READ  = 3'd2,
      ST_MIX   = 3'd3,
      ST_WRITE = 3'd4
   } echo_state_e;

   // Bypass stage index on which a dry sample taken during CLEAR is emitted,
   // giving it the same strobe-to-valid latency as a mixed sample.
   localparam logic [1:0] PASS_LAST = 2'd3;

endpackage

// File: rtl/echo_effect_if.sv
// Sample stream bundle between note_player, the echo stage and the codec path.
// Handshake: sample_in_valid and sample_out_valid are single-cycle strobes with no back-pressure.
interface echo_effect_if #(
   parameter int ADDR_WIDTH   = 12,
   parameter int SAMPLE_WIDTH = 16
);
   logic signed [SAMPLE_WIDTH-1:0] sample_in;
   logic                           sample_in_valid;
   logic                           echo_enable;
   logic [ADDR_WIDTH-1:0]          delay_len;
   logic signed [SAMPLE_WIDTH-1:0] sample_out;
   logic                           sample_out_valid;
   logic                           echo_ready;
   logic                           overrun;

   modport master (
      output sample_in, sample_in_valid, echo_enable, delay_len,
      input  sample_out, sample_out_valid, echo_ready, overrun
   );

   modport slave (
      input  sample_in, sample_in_valid, echo_enable, delay_len,
      output sample_out, sample_out_valid, echo_ready, overrun
   );
endinterface

// File: rtl/echo_effect_ram.sv
// Single-port synchronous delay-line RAM with one-cycle read latency.
// A write also returns the written word on rd_data (write-first).
module echo_ram #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_data;
         rd_data_q <= wr_data;
      end else begin
         rd_data_q <= mem[addr];
      end
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/echo_effect.sv
// Regenerative echo: each accepted sample is mixed with an attenuated copy of the
// sample delay_len positions back, saturated, emitted and written back into the buffer.
module echo_effect
   import echo_effect_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ATTEN_SHIFT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   echo_effect_if.slave bus,
   output echo_state_e state_dbg
);
   localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

   echo_state_e state_q, state_d;
   logic [ADDR_WIDTH-1:0]          clr_cnt_q, clr_cnt_d;
   logic [ADDR_WIDTH-1:0]          wr_ptr_q, wr_ptr_d;
   logic signed [SAMPLE_WIDTH-1:0] in_q, in_d;
   logic                           en_q, en_d;
   logic [ADDR_WIDTH-1:0]          dly_q, dly_d;
   logic signed [SAMPLE_WIDTH-1:0] result_q, result_d;
   logic signed [SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
   logic                           out_valid_q, out_valid_d;
   logic                           echo_ready_q, echo_ready_d;
   logic                           overrun_q, overrun_d;
   logic [1:0]                     pass_cnt_q, pass_cnt_d;
   logic signed [SAMPLE_WIDTH-1:0] pass_data_q, pass_data_d;

   logic                           ram_we;
   logic [ADDR_WIDTH-1:0]          ram_addr;
   logic [SAMPLE_WIDTH-1:0]        ram_wdata;
   logic [SAMPLE_WIDTH-1:0]        ram_rdata;
   logic signed [SAMPLE_WIDTH-1:0] rd_data;
   logic signed [SAMPLE_WIDTH-1:0] delayed;
   logic signed [SAMPLE_WIDTH:0]   sum;
   logic signed [SAMPLE_WIDTH-1:0] mixed;
   logic                           strobe;

   assign strobe  = bus.sample_in_valid;
   assign rd_data = ram_rdata;

   echo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (SAMPLE_WIDTH)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .addr    (ram_addr),
      .wr_data (ram_wdata),
      .rd_data (ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         clr_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         in_q         <= '0;
         en_q         <= 1'b0;
         dly_q        <= '0;
         result_q     <= '0;
         sample_out_q <= '0;
         out_valid_q  <= 1'b0;
         echo_ready_q <= 1'b0;
         overrun_q    <= 1'b0;
         pass_cnt_q   <= '0;
         pass_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         in_q         <= in_d;
         en_q         <= en_d;
         dly_q        <= dly_d;
         result_q     <= result_d;
         sample_out_q <= sample_out_d;
         out_valid_q  <= out_valid_d;
         echo_ready_q <= echo_ready_d;
         overrun_q    <= overrun_d;
         pass_cnt_q   <= pass_cnt_d;
         pass_data_q  <= pass_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (clr_cnt_q == '1) state_d = ST_IDLE;
         ST_IDLE:  if (strobe) state_d = ST_READ;
         ST_READ:  state_d = ST_MIX;
         ST_MIX:   state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_CLEAR;
      endcase
   end

   // Mixer: widen by one bit so the sum cannot wrap, then clamp to the sample range.
   always_comb begin
      delayed = rd_data >>> ATTEN_SHIFT;
      sum     = {in_q[SAMPLE_WIDTH-1], in_q} + {delayed[SAMPLE_WIDTH-1], delayed};
      mixed   = sum[SAMPLE_WIDTH-1:0];
      if (sum[SAMPLE_WIDTH] != sum[SAMPLE_WIDTH-1]) begin
         mixed = sum[SAMPLE_WIDTH] ? SAMPLE_MIN : SAMPLE_MAX;
      end
   end

   always_comb begin
      clr_cnt_d    = clr_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      in_d         = in_q;
      en_d         = en_q;
      dly_d        = dly_q;
      result_d     = result_q;
      sample_out_d = sample_out_q;
      out_valid_d  = 1'b0;
      echo_ready_d = echo_ready_q;
      overrun_d    = overrun_q;
      pass_cnt_d   = pass_cnt_q;
      pass_data_d  = pass_data_q;
      ram_we       = 1'b0;
      ram_addr     = wr_ptr_q - dly_q;
      ram_wdata    = result_q;

      // The dry bypass runs alongside CLEAR because the RAM port is busy clearing.
      if (pass_cnt_q != 2'd0) begin
         pass_cnt_d = pass_cnt_q + 2'd1;
         if (pass_cnt_q == PASS_LAST) begin
            sample_out_d = pass_data_q;
            out_valid_d  = 1'b1;
         end
      end

      case (state_q)
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            ram_wdata = '0;
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == '1) echo_ready_d = 1'b1;
            if (strobe) begin
               if (pass_cnt_q == 2'd0) begin
                  pass_cnt_d  = 2'd1;
                  pass_data_d = bus.sample_in;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (strobe) begin
               in_d  = bus.sample_in;
               en_d  = bus.echo_enable;
               dly_d = bus.delay_len;
            end
         end
         ST_READ: begin
            if (strobe) overrun_d = 1'b1;
         end
         ST_MIX: begin
            result_d = (en_q && (dly_q != '0)) ? mixed : in_q;
            if (strobe) overrun_d = 1'b1;
         end
         ST_WRITE: begin
            ram_we       = 1'b1;
            ram_addr     = wr_ptr_q;
            ram_wdata    = result_q;
            wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
            sample_out_d = result_q;
            out_valid_d  = 1'b1;
            if (strobe) overrun_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.sample_out       = sample_out_q;
   assign bus.sample_out_valid = out_valid_q;
   assign bus.echo_ready       = echo_ready_q;
   assign bus.overrun          = overrun_q;
   assign state_dbg            = state_q;
endmodule
